// File: rtl/fence_t_seq_pkg.sv
// Shared types and constants for the fence.t flush sequencer.
package fence_t_seq_pkg;

    localparam int unsigned FENCE_T_NR_TARGETS = 14;

    localparam int unsigned FT_DCACHE = 4;
    localparam int unsigned FT_ICACHE = 5;
    localparam int unsigned FT_TLB    = 6;

    // Targets that must acknowledge their flush before the sequence moves on.
    localparam logic [FENCE_T_NR_TARGETS-1:0] FENCE_T_ACK_MASK =
        (14'd1 << FT_DCACHE) | (14'd1 << FT_ICACHE);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        PAD,
        DONE
    } fence_t_seq_state_e;

endpackage

// File: rtl/fence_t_seq_counter.sv
// Loadable up/down counter; the sequencer uses it as the pad countdown.
module fence_t_seq_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = d_i;
        end else if (en_i) begin
            cnt_d = down_i ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/fence_t_seq.sv
// fence.t sequencer: flushes targets one at a time, waits for acks with a
// timeout, pads past the next timer-interrupt edge, and halts commit meanwhile.
module fence_t_seq
    import fence_t_seq_pkg::*;
#(
    parameter int unsigned            NR_TARGETS  = FENCE_T_NR_TARGETS,
    parameter logic [NR_TARGETS-1:0]  ACK_MASK    = FENCE_T_ACK_MASK,
    parameter int unsigned            ACK_TIMEOUT = 1024,
    parameter int unsigned            PAD_WIDTH   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [NR_TARGETS-1:0] req_mask_i,
    input  logic [PAD_WIDTH-1:0]  pad_cycles_i,
    input  logic                  time_irq_i,
    output logic [NR_TARGETS-1:0] flush_o,
    input  logic [NR_TARGETS-1:0] flush_ack_i,
    output logic                  halt_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic [31:0]           cycles_o
);

    localparam int unsigned TIMER_W = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned CYC_W   = 32;

    fence_t_seq_state_e    state_q, state_d;
    logic [NR_TARGETS-1:0] pending_q, pending_d;
    logic [NR_TARGETS-1:0] flush_q, flush_d;
    logic [PAD_WIDTH-1:0]  pad_q, pad_d, pad_cnt;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [CYC_W-1:0]      cycles_q, cycles_d;
    logic                  armed_q, armed_d;
    logic                  edge_seen_q, edge_seen_d;
    logic                  time_irq_q;
    logic                  ready_q, ready_d;
    logic                  halt_q, halt_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic                  accept, irq_edge, pad_load, ack_hit, is_ack_tgt;

    assign accept     = req_valid_i && ready_q;
    assign irq_edge   = time_irq_i && !time_irq_q;
    assign pad_load   = irq_edge && armed_q && (state_q != IDLE);
    // flush_q always holds the one-hot of the target currently being flushed.
    assign ack_hit    = |(flush_q & flush_ack_i);
    assign is_ack_tgt = |(flush_q & ACK_MASK);

    fence_t_seq_counter #(
        .WIDTH (PAD_WIDTH)
    ) i_pad_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (1'b0),
        .en_i    (pad_cnt != '0),
        .load_i  (pad_load),
        .down_i  (1'b1),
        .d_i     (pad_q),
        .q_o     (pad_cnt)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        pad_d       = pad_q;
        timer_d     = timer_q;
        armed_d     = armed_q;
        edge_seen_d = edge_seen_q;
        timeout_d   = timeout_q;
        cycles_d    = cycles_q;
        flush_d     = '0;

        if (pad_load) begin
            armed_d     = 1'b0;
            edge_seen_d = 1'b1;
        end

        if ((state_q != IDLE) && (state_q != DONE) && (cycles_q != '1)) begin
            cycles_d = cycles_q + CYC_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    pending_d   = req_mask_i;
                    pad_d       = pad_cycles_i;
                    timeout_d   = 1'b0;
                    cycles_d    = CYC_W'(1);
                    edge_seen_d = 1'b0;
                    armed_d     = 1'b1;
                    state_d     = (|req_mask_i) ? ISSUE : PAD;
                end
            end
            ISSUE: begin
                pending_d = pending_q & ~flush_q;
                if (is_ack_tgt && !ack_hit) begin
                    state_d = WAIT_ACK;
                    timer_d = TIMER_W'(1);
                end else begin
                    state_d = (|pending_d) ? ISSUE : PAD;
                end
            end
            WAIT_ACK: begin
                if (ack_hit || (timer_q == TIMER_W'(ACK_TIMEOUT - 1))) begin
                    timeout_d = timeout_q | !ack_hit;
                    state_d   = (|pending_q) ? ISSUE : PAD;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            PAD: begin
                if (edge_seen_q && (pad_cnt == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state presents.
        if (state_d == ISSUE) begin
            flush_d = pending_d & (~pending_d + NR_TARGETS'(1));
        end else if (state_d == WAIT_ACK) begin
            flush_d = flush_q;
        end
        ready_d = (state_d == IDLE);
        halt_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            pad_q       <= '0;
            timer_q     <= '0;
            cycles_q    <= '0;
            armed_q     <= 1'b0;
            edge_seen_q <= 1'b0;
            time_irq_q  <= 1'b0;
            flush_q     <= '0;
            ready_q     <= 1'b1;
            halt_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            pad_q       <= pad_d;
            timer_q     <= timer_d;
            cycles_q    <= cycles_d;
            armed_q     <= armed_d;
            edge_seen_q <= edge_seen_d;
            time_irq_q  <= time_irq_i;
            flush_q     <= flush_d;
            ready_q     <= ready_d;
            halt_q      <= halt_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign req_ready_o = ready_q;
    assign flush_o     = flush_q;
    assign halt_o      = halt_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign cycles_o    = cycles_q;

endmodule
